riscv_mem_port_arbiter: RTL and testbench

//  Shares one memory request/response port among the core's three memory ports:

---
 rtl/riscv_mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_riscv_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_port_arbiter.sv
// Shares one memory request/response port among imemreq0, imemreq1 and dmemreq.
// Grants are combinational; an in-order tag FIFO steers each response to the port that issued it.
module riscv_mem_port_arbiter #(
  parameter int unsigned REQ_SZ       = 67,
  parameter int unsigned RESP_SZ      = 35,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic [REQ_SZ-1:0]  imemreq0_msg,
  input  logic               imemreq0_val,
  output logic               imemreq0_rdy,
  output logic [RESP_SZ-1:0] imemresp0_msg,
  output logic               imemresp0_val,

  input  logic [REQ_SZ-1:0]  imemreq1_msg,
  input  logic               imemreq1_val,
  output logic               imemreq1_rdy,
  output logic [RESP_SZ-1:0] imemresp1_msg,
  output logic               imemresp1_val,

  input  logic [REQ_SZ-1:0]  dmemreq_msg,
  input  logic               dmemreq_val,
  output logic               dmemreq_rdy,
  output logic [RESP_SZ-1:0] dmemresp_msg,
  output logic               dmemresp_val,

  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,

  output logic               err_unexp_resp
);

  localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ID_IMEM0 = 2'd0;
  localparam logic [1:0] ID_IMEM1 = 2'd1;
  localparam logic [1:0] ID_DMEM  = 2'd2;

  logic [1:0]       tag_q [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             rr_ptr_q;   // 0: imem0 wins the next fetch tie
  logic             err_q;

  logic       full;
  logic       empty;
  logic [1:0] grant_id;
  logic       grant_vld;
  logic       fire;
  logic       pop;
  logic [1:0] head_id;

  assign full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign empty = (count_q == '0);

  // dmem has strict priority; fetch ports share round-robin
  always_comb begin
    grant_id = ID_IMEM0;
    if (dmemreq_val)                       grant_id = ID_DMEM;
    else if (imemreq0_val && imemreq1_val) grant_id = rr_ptr_q ? ID_IMEM1 : ID_IMEM0;
    else if (imemreq1_val)                 grant_id = ID_IMEM1;
  end

  assign grant_vld = reset_n & (imemreq0_val | imemreq1_val | dmemreq_val) & ~full;
  assign fire      = grant_vld & memreq_rdy;

  assign memreq_val   = grant_vld;
  assign memreq_msg   = (grant_id == ID_DMEM)  ? dmemreq_msg  :
                        (grant_id == ID_IMEM1) ? imemreq1_msg : imemreq0_msg;
  assign imemreq0_rdy = fire & (grant_id == ID_IMEM0);
  assign imemreq1_rdy = fire & (grant_id == ID_IMEM1);
  assign dmemreq_rdy  = fire & (grant_id == ID_DMEM);

  assign pop     = reset_n & memresp_val & ~empty;
  assign head_id = tag_q[rd_ptr_q];

  assign imemresp0_val = pop & (head_id == ID_IMEM0);
  assign imemresp1_val = pop & (head_id == ID_IMEM1);
  assign dmemresp_val  = pop & (head_id == ID_DMEM);
  assign imemresp0_msg = memresp_msg;
  assign imemresp1_msg = memresp_msg;
  assign dmemresp_msg  = memresp_msg;

  assign err_unexp_resp = err_q;

  // Tag storage needs no reset: entries are only read below count_q
  always_ff @(posedge clk) begin
    if (fire) tag_q[wr_ptr_q] <= grant_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (fire) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (grant_id == ID_IMEM0)      rr_ptr_q <= 1'b1;
        else if (grant_id == ID_IMEM1) rr_ptr_q <= 1'b0;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({fire, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (memresp_val && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Randomized and directed bench for riscv_mem_port_arbiter with a queue-based reference model
// and a scoreboard monitor for grants and routed responses.
module tb_riscv_mem_port_arbiter;

  localparam int unsigned REQ_SZ  = 67;
  localparam int unsigned RESP_SZ = 35;
  localparam int unsigned MAXI    = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [REQ_SZ-1:0]  imemreq0_msg, imemreq1_msg, dmemreq_msg, memreq_msg;
  logic               imemreq0_val, imemreq1_val, dmemreq_val, memreq_val;
  logic               imemreq0_rdy, imemreq1_rdy, dmemreq_rdy, memreq_rdy;
  logic [RESP_SZ-1:0] imemresp0_msg, imemresp1_msg, dmemresp_msg, memresp_msg;
  logic               imemresp0_val, imemresp1_val, dmemresp_val, memresp_val;
  logic               err_unexp_resp;

  always #5 clk = ~clk;

  riscv_mem_port_arbiter #(.REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset_n(reset_n),
    .imemreq0_msg(imemreq0_msg), .imemreq0_val(imemreq0_val), .imemreq0_rdy(imemreq0_rdy),
    .imemresp0_msg(imemresp0_msg), .imemresp0_val(imemresp0_val),
    .imemreq1_msg(imemreq1_msg), .imemreq1_val(imemreq1_val), .imemreq1_rdy(imemreq1_rdy),
    .imemresp1_msg(imemresp1_msg), .imemresp1_val(imemresp1_val),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .err_unexp_resp(err_unexp_resp)
  );

  typedef struct {
    bit                vld;
    bit [2:0]          rdy;
    logic [REQ_SZ-1:0] msg;
    bit                err;
  } exp_req_t;

  typedef struct {
    int                 port;
    logic [RESP_SZ-1:0] msg;
  } exp_resp_t;

  exp_req_t  req_q[$];
  exp_resp_t resp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: outstanding issuer IDs in order, preferred fetch port, sticky error
  int  tags[$];
  int  pref = 0;
  bit  err_m = 1'b0;
  bit  p_val[3];
  logic [REQ_SZ-1:0] p_msg[3];
  int  grants[3];

  function automatic logic [REQ_SZ-1:0] rand_req();
    return REQ_SZ'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [RESP_SZ-1:0] rand_resp();
    return RESP_SZ'({$urandom(), $urandom()});
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expectations are pushed for the monitor
  task automatic cycle(input bit mrdy, input bit rv, input logic [RESP_SZ-1:0] rmsg);
    int g;
    bit pop;
    exp_req_t e;
    exp_resp_t r;
    @(negedge clk);
    imemreq0_val = p_val[0]; imemreq0_msg = p_msg[0];
    imemreq1_val = p_val[1]; imemreq1_msg = p_msg[1];
    dmemreq_val  = p_val[2]; dmemreq_msg  = p_msg[2];
    memreq_rdy   = mrdy;
    memresp_val  = rv;
    memresp_msg  = rmsg;
    g = -1;
    if (tags.size() < MAXI) begin
      if (p_val[2])                 g = 2;
      else if (p_val[0] && p_val[1]) g = pref;
      else if (p_val[0])            g = 0;
      else if (p_val[1])            g = 1;
    end
    e.vld = (g >= 0);
    e.rdy = (g >= 0 && mrdy) ? 3'(1 << g) : 3'b000;
    e.msg = (g >= 0) ? p_msg[g] : '0;
    e.err = err_m;
    pop = rv && (tags.size() > 0);
    #1;
    req_q.push_back(e);
    if (pop) begin
      r.port = tags[0];
      r.msg  = rmsg;
      resp_q.push_back(r);
    end
    @(posedge clk);
    if (pop) void'(tags.pop_front());
    else if (rv) err_m = 1'b1;
    if (g >= 0 && mrdy) begin
      tags.push_back(g);
      grants[g]++;
      p_val[g] = 1'b0;
      if (g != 2) pref = 1 - g;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("rst_memreq_val", memreq_val, 1'b0);
    check_bit("rst_rdy_any", imemreq0_rdy | imemreq1_rdy | dmemreq_rdy, 1'b0);
    check_bit("rst_resp_val_any", imemresp0_val | imemresp1_val | dmemresp_val, 1'b0);
    check_bit("rst_err", err_unexp_resp, 1'b0);
    tags.delete();
    pref  = 0;
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    reset_n     = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && tags.size() > 0; i++) cycle(1'b0, 1'b1, rand_resp());
  endtask

  // Monitor: compares handshake outputs every cycle, pops routed responses when presented
  initial begin
    exp_req_t  e;
    exp_resp_t r;
    logic [2:0] rv;
    logic [RESP_SZ-1:0] rmsg;
    forever begin
      @(negedge clk);
      #2;
      if (req_q.size() > 0) begin
        e = req_q.pop_front();
        check_bit("memreq_val", memreq_val, e.vld);
        checks++;
        if ({dmemreq_rdy, imemreq1_rdy, imemreq0_rdy} !== e.rdy) begin
          errors++;
          $display("FAIL rdy got %b expected %b at %0t",
                   {dmemreq_rdy, imemreq1_rdy, imemreq0_rdy}, e.rdy, $time);
        end
        if (e.vld) begin
          checks++;
          if (memreq_msg !== e.msg) begin
            errors++;
            $display("FAIL memreq_msg got %h expected %h at %0t", memreq_msg, e.msg, $time);
          end
        end
        check_bit("err_unexp_resp", err_unexp_resp, e.err);
      end
      rv = {dmemresp_val, imemresp1_val, imemresp0_val};
      if (rv != 3'b000 || resp_q.size() > 0) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got %b expected 000 at %0t", rv, $time);
        end else begin
          r = resp_q.pop_front();
          rmsg = (r.port == 2) ? dmemresp_msg : (r.port == 1) ? imemresp1_msg : imemresp0_msg;
          if (rv !== 3'(1 << r.port) || rmsg !== r.msg) begin
            errors++;
            $display("FAIL resp_route got val %b msg %h expected val %b msg %h at %0t",
                     rv, rmsg, 3'(1 << r.port), r.msg, $time);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    imemreq0_val = 1'b0; imemreq1_val = 1'b0; dmemreq_val = 1'b0;
    imemreq0_msg = '0; imemreq1_msg = '0; dmemreq_msg = '0;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
    for (int i = 0; i < 3; i++) begin p_val[i] = 1'b0; p_msg[i] = '0; grants[i] = 0; end
    #1;
    check_bit("init_memreq_val", memreq_val, 1'b0);
    check_bit("init_err", err_unexp_resp, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Unexpected response right after reset: dropped, error sticks
    cycle(1'b0, 1'b1, rand_resp());
    repeat (3) cycle(1'b0, 1'b0, '0);
    do_reset();

    // dmem read of 0x100 returning 0xCAFE two cycles later
    p_val[2] = 1'b1; p_msg[2] = {1'b0, 32'h100, 2'b00, 32'h0};
    cycle(1'b1, 1'b0, '0);
    repeat (2) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, {1'b0, 2'b00, 32'hCAFE});

    // All three valid: dmem, imem0, imem1; then the next fetch tie goes to imem0
    for (int i = 0; i < 3; i++) begin p_val[i] = 1'b1; p_msg[i] = rand_req(); end
    repeat (3) cycle(1'b1, 1'b0, '0);
    drain();
    p_val[0] = 1'b1; p_msg[0] = rand_req();
    p_val[1] = 1'b1; p_msg[1] = rand_req();
    cycle(1'b1, 1'b0, '0);
    p_val[1] = 1'b0;
    drain();

    // Fetch ports held valid for 8 cycles alternate grants
    grants[0] = 0; grants[1] = 0;
    for (int i = 0; i < 8; i++) begin
      p_val[0] = 1'b1; p_val[1] = 1'b1;
      p_msg[0] = rand_req(); p_msg[1] = rand_req();
      cycle(1'b1, tags.size() > 0, rand_resp());
    end
    p_val[0] = 1'b0; p_val[1] = 1'b0;
    checks++;
    if (grants[0] != 4 || grants[1] != 4) begin
      errors++;
      $display("FAIL rr_balance got %0d/%0d expected 4/4", grants[0], grants[1]);
    end
    drain();

    // Fill to MAX_INFLIGHT, stall, then one response frees a slot for the next cycle
    for (int i = 0; i < 5; i++) begin
      p_val[0] = 1'b1; p_msg[0] = rand_req();
      cycle(1'b1, 1'b0, '0);
    end
    cycle(1'b1, 1'b1, rand_resp());
    cycle(1'b1, 1'b0, '0);
    drain();

    // Reset with two requests outstanding, then normal operation
    for (int i = 0; i < 2; i++) begin
      p_val[2] = 1'b1; p_msg[2] = rand_req();
      cycle(1'b1, 1'b0, '0);
    end
    p_val[0] = 1'b1; p_msg[0] = rand_req();
    do_reset();
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, rand_resp());

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++)
        if (!p_val[i] && ($urandom_range(2) == 0)) begin p_val[i] = 1'b1; p_msg[i] = rand_req(); end
      cycle($urandom_range(3) != 0,
            (tags.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(99) == 0),
            rand_resp());
    end
    for (int i = 0; i < 3; i++) p_val[i] = 1'b0;
    drain();
    cycle(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
